// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: first bit one cycle after an accepted start; start is ignored while busy or done.
// Build option SEQ_TX_NOISE_GAP_EN fills inter-frame gaps with bits from an 8-bit LFSR instead of zeros.
module seq_pattern_tx #(
  parameter int PAT_W   = 4,
  parameter int BIT_DIV = 1,
  parameter int REP_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] repeat_cnt,
  input  logic [3:0]       gap_bits,
  output logic             seq_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int DIV_W = $clog2(BIT_DIV + 1);
  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [REP_W-1:0] r_frames, w_frames_nxt;
  logic [3:0]       r_gap_cnt, w_gap_cnt_nxt;
  logic [PAT_W-1:0] r_pat, w_pat_nxt;
  logic [3:0]       r_gap, w_gap_nxt;
  logic             r_seq_out, r_bit_valid, r_busy, r_done;
  logic             w_seq_nxt, w_bv_nxt, w_busy_nxt, w_done_nxt;
  logic             w_bit_end;
  logic             w_noise_bit;

  assign w_bit_end = (r_div == DIV_LAST);

`ifdef SEQ_TX_NOISE_GAP_EN
  logic [7:0] r_lfsr;
  logic [7:0] w_lfsr_nxt;

  // Steps once at the end of every gap bit period, holds otherwise.
  always_comb begin
    w_lfsr_nxt = r_lfsr;
    if (r_state == S_GAP && w_bit_end)
      w_lfsr_nxt = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_lfsr <= 8'hA5;
    else        r_lfsr <= w_lfsr_nxt;
  end

  assign w_noise_bit = w_lfsr_nxt[0];
`else
  assign w_noise_bit = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_div_nxt     = r_div;
    w_idx_nxt     = r_idx;
    w_frames_nxt  = r_frames;
    w_gap_cnt_nxt = r_gap_cnt;
    w_pat_nxt     = r_pat;
    w_gap_nxt     = r_gap;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt   = S_SEND;
          w_pat_nxt     = pattern;
          w_gap_nxt     = gap_bits;
          w_frames_nxt  = (repeat_cnt == '0) ? REP_W'(1) : repeat_cnt;
          w_idx_nxt     = IDX_MSB;
          w_div_nxt     = '0;
          w_gap_cnt_nxt = '0;
        end
      end
      S_SEND: begin
        if (w_bit_end) begin
          w_div_nxt = '0;
          if (r_idx != '0) begin
            w_idx_nxt = r_idx - IDX_W'(1);
          end else if (r_frames > REP_W'(1)) begin
            w_frames_nxt  = r_frames - REP_W'(1);
            w_idx_nxt     = IDX_MSB;
            w_gap_cnt_nxt = '0;
            w_state_nxt   = (r_gap != 4'd0) ? S_GAP : S_SEND;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      S_GAP: begin
        if (w_bit_end) begin
          w_div_nxt = '0;
          if (r_gap_cnt == r_gap - 4'd1) begin
            w_state_nxt   = S_SEND;
            w_idx_nxt     = IDX_MSB;
            w_gap_cnt_nxt = '0;
          end else begin
            w_gap_cnt_nxt = r_gap_cnt + 4'd1;
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_div_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    w_busy_nxt = (w_state_nxt == S_SEND) || (w_state_nxt == S_GAP);
    w_done_nxt = (w_state_nxt == S_DONE);
    w_bv_nxt   = (w_state_nxt == S_SEND) && (w_div_nxt == '0);
    w_seq_nxt  = 1'b0;
    if (w_state_nxt == S_SEND)     w_seq_nxt = w_pat_nxt[w_idx_nxt];
    else if (w_state_nxt == S_GAP) w_seq_nxt = w_noise_bit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_idx       <= '0;
      r_frames    <= '0;
      r_gap_cnt   <= '0;
      r_pat       <= '0;
      r_gap       <= '0;
      r_seq_out   <= 1'b0;
      r_bit_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_div       <= w_div_nxt;
      r_idx       <= w_idx_nxt;
      r_frames    <= w_frames_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_pat       <= w_pat_nxt;
      r_gap       <= w_gap_nxt;
      r_seq_out   <= w_seq_nxt;
      r_bit_valid <= w_bv_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign seq_out   = r_seq_out;
  assign bit_valid = r_bit_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: two instances (BIT_DIV 1 and 3) share stimulus and are checked
// cycle by cycle against an arithmetic model of the expected serial stream.
module tb_seq_pattern_tx;

  localparam int PW = 4;
  localparam int RW = 4;
`ifdef SEQ_TX_NOISE_GAP_EN
  localparam bit NOISE = 1'b1;
`else
  localparam bit NOISE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [PW-1:0] pattern;
  logic [RW-1:0] repeat_cnt;
  logic [3:0]    gap_bits;
  logic [1:0]    seq_out, bit_valid, busy, done;

  int total_cnt = 0;
  int bad_cnt   = 0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.PAT_W(PW), .BIT_DIV(1), .REP_W(RW)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .repeat_cnt(repeat_cnt), .gap_bits(gap_bits),
    .seq_out(seq_out[0]), .bit_valid(bit_valid[0]), .busy(busy[0]), .done(done[0])
  );

  seq_pattern_tx #(.PAT_W(PW), .BIT_DIV(3), .REP_W(RW)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .repeat_cnt(repeat_cnt), .gap_bits(gap_bits),
    .seq_out(seq_out[1]), .bit_valid(bit_valid[1]), .busy(busy[1]), .done(done[1])
  );

  // Model state per instance: t_cyc counts cycles since launch; busy for tot cycles,
  // then one done cycle, then one cycle in which start is still ignored.
  int            div_of [2] = '{1, 3};
  bit            act [2];
  int            t_cyc [2];
  int            tot [2];
  int            rep [2];
  int            gap [2];
  logic [PW-1:0] pat [2];
  int            nbase [2];
  int            busy_seen [2];
  logic [7:0]    lfsr_tab [255];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    if (obs !== exp_v) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_inst(input int k);
    logic e_seq, e_bv, e_busy, e_done;
    int   d, per, pos, f, g;
    e_seq = 1'b0; e_bv = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    d = div_of[k];
    if (act[k]) begin
      if (t_cyc[k] < tot[k]) begin
        e_busy = 1'b1;
        per    = (PW + gap[k]) * d;
        f      = t_cyc[k] / per;
        pos    = t_cyc[k] % per;
        if (pos < PW * d) begin
          e_seq = pat[k][PW - 1 - pos / d];
          e_bv  = (pos % d == 0);
        end else begin
          g = (pos - PW * d) / d;
          if (NOISE) e_seq = lfsr_tab[(nbase[k] + f * gap[k] + g) % 255][0];
        end
      end else if (t_cyc[k] == tot[k]) begin
        e_done = 1'b1;
      end
    end
    chk($sformatf("seq_out[%0d]", k),   32'(seq_out[k]),   32'(e_seq));
    chk($sformatf("bit_valid[%0d]", k), 32'(bit_valid[k]), 32'(e_bv));
    chk($sformatf("busy[%0d]", k),      32'(busy[k]),      32'(e_busy));
    chk($sformatf("done[%0d]", k),      32'(done[k]),      32'(e_done));
    if (busy[k]) busy_seen[k]++;
    if (act[k]) begin
      if (t_cyc[k] == tot[k])
        chk($sformatf("busy_cycles[%0d]", k), 32'(busy_seen[k]), 32'(tot[k]));
      if (t_cyc[k] == tot[k] + 1) begin
        act[k]   = 1'b0;
        nbase[k] += (rep[k] - 1) * gap[k];
      end else begin
        t_cyc[k]++;
      end
    end
  endtask

  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      if (reset && start && !act[k]) begin
        act[k]       = 1'b1;
        t_cyc[k]     = 0;
        pat[k]       = pattern;
        rep[k]       = (repeat_cnt == '0) ? 1 : int'(repeat_cnt);
        gap[k]       = int'(gap_bits);
        tot[k]       = div_of[k] * (rep[k] * PW + (rep[k] - 1) * gap[k]);
        busy_seen[k] = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) check_inst(k);
  endtask

  task automatic launch(input logic [PW-1:0] p, input int r, input int g);
    pattern    = p;
    repeat_cnt = RW'(r);
    gap_bits   = 4'(g);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    pattern    = 4'($urandom);
    repeat_cnt = RW'($urandom);
    gap_bits   = 4'($urandom);
  endtask

  task automatic run_idle(input int limit);
    int n;
    n = 0;
    while ((act[0] || act[1]) && n < limit) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(act[0] | act[1]), 32'd0);
    tick();
  endtask

  // Called just after a sampling point; asserts reset between clock edges.
  task automatic async_reset_mid();
    #3 reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_seq_out[%0d]", k),   32'(seq_out[k]),   32'd0);
      chk($sformatf("rst_bit_valid[%0d]", k), 32'(bit_valid[k]), 32'd0);
      chk($sformatf("rst_busy[%0d]", k),      32'(busy[k]),      32'd0);
      chk($sformatf("rst_done[%0d]", k),      32'(done[k]),      32'd0);
      act[k]   = 1'b0;
      nbase[k] = 0;
    end
  endtask

  initial begin
    logic [7:0] l;
    l = 8'hA5;
    for (int i = 0; i < 255; i++) begin
      lfsr_tab[i] = l;
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    for (int k = 0; k < 2; k++) begin
      act[k] = 1'b0; t_cyc[k] = 0; nbase[k] = 0; busy_seen[k] = 0;
      tot[k] = 0; rep[k] = 1; gap[k] = 0; pat[k] = '0;
    end
    reset      = 1'b1;
    start      = 1'b0;
    pattern    = '0;
    repeat_cnt = '0;
    gap_bits   = '0;
    #1 reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("init_seq_out[%0d]", k), 32'(seq_out[k]), 32'd0);
      chk($sformatf("init_busy[%0d]", k),    32'(busy[k]),    32'd0);
      chk($sformatf("init_done[%0d]", k),    32'(done[k]),    32'd0);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();

    launch(4'b1011, 1, 0); run_idle(100);
    launch(4'b1011, 3, 2); run_idle(200);
    launch(4'b1011, 0, 5); run_idle(100);
    launch(4'b0110, 1, 0); run_idle(100);
    launch(4'b1001, 2, 4); run_idle(200);

    // Mid-frame restart attempt, then reset in the middle of a frame.
    launch(4'b1011, 2, 1);
    tick();
    pattern = 4'b0000;
    start   = 1'b1;
    tick();
    tick();
    start = 1'b0;
    tick();
    async_reset_mid();
    tick();
    tick();
    reset = 1'b1;
    tick();
    launch(4'b1101, 1, 0); run_idle(100);

    for (int c = 0; c < 4000; c++) begin
      start      = ($urandom_range(0, 3) == 0);
      pattern    = 4'($urandom);
      repeat_cnt = RW'($urandom);
      gap_bits   = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      if ($urandom_range(0, 799) == 0) begin
        async_reset_mid();
        tick();
        reset = 1'b1;
      end else begin
        tick();
      end
    end
    start = 1'b0;
    run_idle(3000);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
